pipe_skid_stage: RTL and testbench

- Parametrised pipeline-stage register. It is the successor to the fixed-field inter-stage buffers in the CPU pipeline.
- Carries an opaque payload split into a data field and a control field. Control covers write enables, isLW-style flags and opcode.
- Adds a valid/ready handshake with a 2-entry skid buffer, so a downstream stall never drops an instruction and in_ready stays registered.
- Flush kills in-flight entries. Killed or empty slots always present all-zero control, so the downstream stage sees a NOP.

---
 rtl/pipe_pkg.sv | 24 ++
 rtl/pipe_slot_reg.sv | 42 ++++
 rtl/pipe_skid_stage.sv | 103 ++++++++++
 tb/tb_pipe_skid_stage.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: default field widths,
// the NOP control word and the slot record layout.
package pipe_pkg;

  localparam int PC_W       = 32;
  localparam int REG_IDX_W  = 4;
  localparam int ALU_OP_W   = 4;
  localparam int DEF_DATA_W = 128;
  localparam int DEF_CTRL_W = 16;

  localparam logic [DEF_CTRL_W-1:0] CTRL_NOP = '0;

  typedef struct packed {
    logic                  valid;
    logic [DEF_CTRL_W-1:0] ctrl;
    logic [DEF_DATA_W-1:0] data;
  } slot_t;

  // Number of valid entries given the main and skid valid bits.
  function automatic logic [1:0] count_valid(input logic main_v, input logic skid_v);
    return {main_v & skid_v, main_v ^ skid_v};
  endfunction

endpackage

// File: rtl/pipe_slot_reg.sv
// One payload slot: load, drop, kill (highest priority) and async reset.
// The stored control word is always zero while the slot is invalid.
module pipe_slot_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int CTRL_W   = DEF_CTRL_W,
  parameter bit CLR_DATA = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              kill,
  input  logic              load,
  input  logic              drop,
  input  logic [DATA_W-1:0] load_data,
  input  logic [CTRL_W-1:0] load_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      ctrl  <= '0;
    end else if (kill) begin
      valid <= 1'b0;
      ctrl  <= '0;
      if (CLR_DATA) data <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      ctrl  <= load_ctrl;
    end else if (drop) begin
      // Data stays stale on a normal drain; only control must read as NOP.
      valid <= 1'b0;
      ctrl  <= '0;
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// Define PIPE_SKID_STAGE_PERF_EN to add saturating stall_cnt / flush_cnt outputs.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int CTRL_W   = DEF_CTRL_W,
  parameter bit CLR_DATA = 1'b0,
  parameter int PERF_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
`ifdef PIPE_SKID_STAGE_PERF_EN
  ,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt
`endif
);

  logic              m_valid, s_valid;
  logic [DATA_W-1:0] m_data, s_data;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl;
  logic              acc, pop;
  logic              m_load, m_drop, s_load, s_drop;
  logic [DATA_W-1:0] m_src_data;
  logic [CTRL_W-1:0] m_src_ctrl;

  assign acc = in_valid && in_ready && !flush;
  assign pop = m_valid && out_ready;

  // acc is impossible while S is full, so M refills from S in that case.
  assign m_load = (acc && (!m_valid || pop)) || (s_valid && pop && !flush);
  assign m_drop = m_valid && !s_valid && pop && !acc;
  assign s_load = m_valid && !pop && acc;
  assign s_drop = s_valid && pop;

  assign m_src_data = s_valid ? s_data : in_data;
  assign m_src_ctrl = s_valid ? s_ctrl : in_ctrl;

  pipe_slot_reg #(
    .DATA_W   (DATA_W),
    .CTRL_W   (CTRL_W),
    .CLR_DATA (CLR_DATA)
  ) u_main (
    .clk       (clk),
    .rst_n     (rst_n),
    .kill      (flush),
    .load      (m_load),
    .drop      (m_drop),
    .load_data (m_src_data),
    .load_ctrl (m_src_ctrl),
    .valid     (m_valid),
    .data      (m_data),
    .ctrl      (m_ctrl)
  );

  pipe_slot_reg #(
    .DATA_W   (DATA_W),
    .CTRL_W   (CTRL_W),
    .CLR_DATA (CLR_DATA)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .kill      (flush),
    .load      (s_load),
    .drop      (s_drop),
    .load_data (in_data),
    .load_ctrl (in_ctrl),
    .valid     (s_valid),
    .data      (s_data),
    .ctrl      (s_ctrl)
  );

  // Every output is a flop or a function of flops only.
  assign in_ready  = !s_valid;
  assign out_valid = m_valid;
  assign out_data  = m_data;
  assign out_ctrl  = m_ctrl;
  assign occupancy = count_valid(m_valid, s_valid);

`ifdef PIPE_SKID_STAGE_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (m_valid && !out_ready && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush && m_valid && (flush_cnt != '1))      flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage: the driver queues expected beats,
// a negedge monitor pops and compares each beat the DUT hands downstream.
module tb_pipe_skid_stage;

  localparam int DATA_W = 128;
  localparam int CTRL_W = 16;
  localparam int PERF_W = 32;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;
`ifdef PIPE_SKID_STAGE_PERF_EN
  logic [PERF_W-1:0] stall_cnt;
  logic [PERF_W-1:0] flush_cnt;
`endif

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  pipe_skid_stage #(
    .DATA_W   (DATA_W),
    .CTRL_W   (CTRL_W),
    .CLR_DATA (1'b0),
    .PERF_W   (PERF_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .occupancy (occupancy)
`ifdef PIPE_SKID_STAGE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat, hold it until the handshake fires, then drop in_valid.
  task automatic send_beat(input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                           input bit expect_out, output int waited);
    bit accepted;
    accepted = 1'b0;
    waited   = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_ctrl  = c;
    if (expect_out) exp_q.push_back('{data: d, ctrl: c});
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1'b1;
        break;
      end
      waited++;
    end
    if (!accepted) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: beat %0h not accepted, expected acceptance within 50 cycles", d);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor: a pop happens at the next posedge whenever out_valid && out_ready now.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got %0h, expected no output", out_data);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check("beat_data", out_data, e.data);
        check("beat_ctrl", {{(DATA_W-CTRL_W){1'b0}}, out_ctrl}, {{(DATA_W-CTRL_W){1'b0}}, e.ctrl});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 128'hA5;
    in_ctrl   = 16'h00A5;
    out_ready = 1'b0;

    // Reset with upstream pushing
    repeat (3) tick();
    @(negedge clk);
    check("rst_out_valid", {127'b0, out_valid}, 128'd0);
    check("rst_out_ctrl",  {112'b0, out_ctrl},  128'd0);
    check("rst_in_ready",  {127'b0, in_ready},  128'd1);
    check("rst_occupancy", {126'b0, occupancy}, 128'd0);
    tick();
    in_valid = 1'b0;
    rst_n    = 1'b1;
    tick();

    // First beat: visible exactly one edge after acceptance
    send_beat(128'h10, 16'h0011, 1'b1, w);
    @(negedge clk);
    check("lat_out_valid", {127'b0, out_valid}, 128'd1);
    check("lat_occupancy", {126'b0, occupancy}, 128'd1);
    tick();
    out_ready = 1'b1;
    tick();
    tick();

    // Streaming back-to-back
    for (int i = 1; i <= 4; i++) begin
      send_beat(DATA_W'(i), CTRL_W'(16'h0100 + i), 1'b1, w);
      check("stream_no_wait", 128'(w), 128'd0);
    end
    tick();
    tick();
    @(negedge clk);
    check("stream_drained", {126'b0, occupancy}, 128'd0);

    // Backpressure: 7 and 8 fill both slots, 9 waits upstream
    tick();
    out_ready = 1'b0;
    send_beat(128'h7, 16'h0007, 1'b1, w);
    send_beat(128'h8, 16'h0008, 1'b1, w);
    fork
      send_beat(128'h9, 16'h0009, 1'b1, w);
      begin
        @(negedge clk);
        check("bp_occupancy", {126'b0, occupancy}, 128'd2);
        check("bp_in_ready",  {127'b0, in_ready},  128'd0);
        tick();
        tick();
        out_ready = 1'b1;
      end
    join
    repeat (3) tick();
    @(negedge clk);
    check("bp_drained", {126'b0, occupancy}, 128'd0);

    // Flush while full; 0x55 offered in the flush cycle must never appear
    tick();
    out_ready = 1'b0;
    send_beat(128'h21, 16'hFFFF, 1'b0, w);
    send_beat(128'h22, 16'hFFFF, 1'b0, w);
    @(negedge clk);
    check("fl_full_occ",  {126'b0, occupancy}, 128'd2);
    check("fl_full_ctrl", {112'b0, out_ctrl},  128'hFFFF);
    tick();
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 128'h55;
    in_ctrl  = 16'h0055;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("fl_out_valid", {127'b0, out_valid}, 128'd0);
    check("fl_out_ctrl",  {112'b0, out_ctrl},  128'd0);
    check("fl_occupancy", {126'b0, occupancy}, 128'd0);
    tick();
    out_ready = 1'b1;
    repeat (3) tick();

    // Flush together with a pop: 0x33 is consumed once, stage ends empty
    out_ready = 1'b0;
    send_beat(128'h33, 16'h00AA, 1'b1, w);
    out_ready = 1'b1;
    flush     = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("fp_out_valid", {127'b0, out_valid}, 128'd0);
    check("fp_out_ctrl",  {112'b0, out_ctrl},  128'd0);
    check("fp_occupancy", {126'b0, occupancy}, 128'd0);
    repeat (2) tick();

    // Asynchronous reset in the middle of a stall
    out_ready = 1'b0;
    send_beat(128'h41, 16'h0041, 1'b0, w);
    send_beat(128'h42, 16'h0042, 1'b0, w);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_out_valid", {127'b0, out_valid}, 128'd0);
    check("ar_occupancy", {126'b0, occupancy}, 128'd0);
    check("ar_in_ready",  {127'b0, in_ready},  128'd1);
    check("ar_out_ctrl",  {112'b0, out_ctrl},  128'd0);
    tick();
    rst_n = 1'b1;
    tick();

`ifdef PIPE_SKID_STAGE_PERF_EN
    // Five stalled edges, one flush of an empty stage, one flush of a full one
    send_beat(128'h60, 16'h0006, 1'b1, w);
    repeat (5) tick();
    out_ready = 1'b1;
    repeat (2) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    send_beat(128'h61, 16'h0061, 1'b1, w);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("perf_stall_cnt", 128'(stall_cnt), 128'd5);
    check("perf_flush_cnt", 128'(flush_cnt), 128'd1);
`endif

    repeat (3) tick();
    check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
